// File: rtl/bnn_pkg.sv
// Shared definitions for the binary 3x3 convolution sequencer.
//  - schedStateT : sequencer FSM states
//  - LINE_W0/1   : pixels per line for the conv2 (sel=0) and conv3 (sel=1) paths
//  - K, WIN_OFS  : kernel size and the row/col offset of the first full window
//  - lineWidth() : line length for a given mode select
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } schedStateT;

    localparam int unsigned LINE_W0 = 16;
    localparam int unsigned LINE_W1 = 14;

    localparam int unsigned K       = 3;
    localparam int unsigned WIN_OFS = K - 1;

    function automatic int unsigned lineWidth(input logic sel);
        return sel ? LINE_W1 : LINE_W0;
    endfunction

endpackage

// File: rtl/bnn_conv_sched_if.sv
// Pixel stream link between the feature-map source and the sequencer.
//  frameReq : 1-cycle pulse from the sequencer, source restarts the map at (0,0)
//  pixValid : source has a pixel on its data lines
//  pixReady : sequencer accepts a pixel
// Handshake: a beat happens on every rising clock edge where pixValid and
// pixReady are both 1. The source may raise pixValid at any time and must hold
// its pixel until the beat; pixReady never depends on pixValid, and neither
// side may retract a pending beat except through reset.
interface bnn_conv_sched_if;
    logic frameReq;
    logic pixValid;
    logic pixReady;

    // Source side
    modport master (
        output pixValid,
        input  pixReady,
        input  frameReq
    );

    // Sequencer side
    modport slave (
        input  pixValid,
        output pixReady,
        output frameReq
    );
endinterface

// File: rtl/bnn_pos_cnt.sv
// Row/column position counter for the pixel stream.
//  iCLK, iRST   : clock, synchronous active-high reset
//  iCLR         : synchronous clear back to (0,0)
//  iADV         : accepted beat, advance one pixel
//  iSEL         : line-mode select (picks the line length)
//  iH           : map height in lines (already clamped)
//  oLAST        : current position is the final pixel of the map
//  oWIN_VALID   : a full 3x3 window ends at the current position
//  oTAG_ROW/COL : output coordinate of that window
module bnn_pos_cnt
    import bnn_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iCLR,
    input  logic          iADV,
    input  logic          iSEL,
    input  logic [CW-1:0] iH,
    output logic          oLAST,
    output logic          oWIN_VALID,
    output logic [CW-1:0] oTAG_ROW,
    output logic [CW-1:0] oTAG_COL
);

    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic [CW-1:0] colLast;

    assign colLast = CW'(lineWidth(iSEL) - 1);

    assign oLAST      = (row == iH - CW'(1)) && (col == colLast);
    // Windows straddling the left or top edge are never full.
    assign oWIN_VALID = (row >= CW'(WIN_OFS)) && (col >= CW'(WIN_OFS));
    assign oTAG_ROW   = row - CW'(WIN_OFS);
    assign oTAG_COL   = col - CW'(WIN_OFS);

    always_ff @(posedge iCLK) begin
        if (iRST || iCLR) begin
            row <= '0;
            col <= '0;
        end else if (iADV) begin
            if (col == colLast) begin
                col <= '0;
                row <= row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bnn_conv_sched.sv
// Sequencer for the binary 3x3 XNOR/popcount convolution datapath.
// For each output channel it clears the datapath, requests a replay of the
// feature map, streams it under valid/ready, and tags the popcount results
// that correspond to full window positions.
// Ports:
//  iCLK, iRST            : clock, synchronous active-high reset
//  iFRAME_START          : pulse to run one layer (only honoured in IDLE)
//  iMODE, iH             : line mode and map height, captured with iFRAME_START
//  pix (slave)           : frameReq / pixValid / pixReady stream link
//  oCONV_START           : 1-cycle datapath clear
//  oCONV_EN              : datapath shift enable (accepted beat)
//  oSEL                  : latched line mode
//  oW_ADDR               : weight ROM address = current channel
//  oOUT_VALID/ROW/COL/CH : result valid flag and its tag, one cycle after the beat
//  oBUSY, oDONE          : not idle / pulse after the final channel
//  oDBG_STATE            : current FSM state
// Optional build macro BNN_CONV_SCHED_PERF_EN adds oPERF_STALL (stream cycles
// without a pixel) and oPERF_CYC (busy cycles), both saturating at 16'hFFFF.
module bnn_conv_sched
    import bnn_pkg::*;
#(
    parameter int MAX_H = 16,
    parameter int N_CH  = 8,
    parameter int CW    = 5
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iFRAME_START,
    input  logic                      iMODE,
    input  logic [CW-1:0]             iH,
    bnn_conv_sched_if.slave           pix,
    output logic                      oCONV_START,
    output logic                      oCONV_EN,
    output logic                      oSEL,
    output logic [$clog2(N_CH)-1:0]   oW_ADDR,
    output logic                      oOUT_VALID,
    output logic [CW-1:0]             oOUT_ROW,
    output logic [CW-1:0]             oOUT_COL,
    output logic [$clog2(N_CH)-1:0]   oOUT_CH,
    output logic                      oBUSY,
    output logic                      oDONE,
`ifdef BNN_CONV_SCHED_PERF_EN
    output logic [15:0]               oPERF_STALL,
    output logic [15:0]               oPERF_CYC,
`endif
    output schedStateT                oDBG_STATE
);

    localparam int CHW = $clog2(N_CH);
    localparam logic [CHW-1:0] LAST_CH = CHW'(N_CH - 1);

    schedStateT      state;
    schedStateT      stateNext;
    logic [CW-1:0]   hLat;
    logic [CHW-1:0]  ch;
    logic            beat;
    logic            startAccept;
    logic            lastCh;
    logic            posLast;
    logic            winValid;
    logic [CW-1:0]   tagRow;
    logic [CW-1:0]   tagCol;

    function automatic logic [CW-1:0] clampH(input logic [CW-1:0] h);
        if (h < CW'(K)) return CW'(K);
        if (h > CW'(MAX_H)) return CW'(MAX_H);
        return h;
    endfunction

    assign startAccept = (state == IDLE) && iFRAME_START;
    assign lastCh      = (ch == LAST_CH);
    assign beat        = pix.pixValid && pix.pixReady;
    assign oCONV_EN    = beat;
    assign oW_ADDR     = ch;
    assign oBUSY       = (state != IDLE);
    assign oDBG_STATE  = state;

    bnn_pos_cnt #(.CW(CW)) uPos (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iCLR       (state == CLEAR),
        .iADV       (beat),
        .iSEL       (oSEL),
        .iH         (hLat),
        .oLAST      (posLast),
        .oWIN_VALID (winValid),
        .oTAG_ROW   (tagRow),
        .oTAG_COL   (tagCol)
    );

    always_comb begin
        stateNext    = state;
        pix.pixReady = 1'b0;
        pix.frameReq = 1'b0;
        oCONV_START  = 1'b0;
        case (state)
            IDLE: begin
                if (iFRAME_START) stateNext = CLEAR;
            end
            CLEAR: begin
                oCONV_START  = 1'b1;
                pix.frameReq = 1'b1;
                stateNext    = STREAM;
            end
            STREAM: begin
                pix.pixReady = 1'b1;
                if (beat && posLast) stateNext = DRAIN;
            end
            DRAIN: begin
                stateNext = lastCh ? IDLE : CLEAR;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= IDLE;
            hLat       <= '0;
            oSEL       <= 1'b0;
            ch         <= '0;
            oOUT_VALID <= 1'b0;
            oOUT_ROW   <= '0;
            oOUT_COL   <= '0;
            oOUT_CH    <= '0;
            oDONE      <= 1'b0;
        end else begin
            state      <= stateNext;
            // oDONE lands in the first IDLE cycle, after the last result has
            // left the output register during DRAIN.
            oDONE      <= (state == DRAIN) && lastCh;
            // The datapath output register is one cycle behind the beat, so
            // the tag is registered to line up with it.
            oOUT_VALID <= beat && winValid;
            if (beat && winValid) begin
                oOUT_ROW <= tagRow;
                oOUT_COL <= tagCol;
                oOUT_CH  <= ch;
            end
            if (startAccept) begin
                oSEL <= iMODE;
                hLat <= clampH(iH);
                ch   <= '0;
            end
            // Channel only moves in DRAIN so weights are stable through
            // CLEAR and STREAM; it wraps to 0 after the final channel.
            if (state == DRAIN) begin
                ch <= lastCh ? '0 : ch + CHW'(1);
            end
        end
    end

`ifdef BNN_CONV_SCHED_PERF_EN
    always_ff @(posedge iCLK) begin
        if (iRST || startAccept) begin
            oPERF_STALL <= '0;
            oPERF_CYC   <= '0;
        end else begin
            if (oBUSY && (oPERF_CYC != 16'hFFFF)) begin
                oPERF_CYC <= oPERF_CYC + 16'd1;
            end
            if ((state == STREAM) && !pix.pixValid && (oPERF_STALL != 16'hFFFF)) begin
                oPERF_STALL <= oPERF_STALL + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bnn_conv_sched.sv
// Self-checking bench for bnn_conv_sched (N_CH=2).
// The reference model lists every expected result tag from the layer
// parameters (channel, window row, window col) and derives beat positions
// from the running count of accepted beats.
module tb_bnn_conv_sched;
    import bnn_pkg::*;

    localparam int N_CH  = 2;
    localparam int MAX_H = 16;
    localparam int CW    = 5;
    localparam int TW    = 1 + 2 * CW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          frameStart;
    logic          modeIn;
    logic [CW-1:0] hIn;
    logic          convStart;
    logic          convEn;
    logic          sel;
    logic [0:0]    wAddr;
    logic          outValid;
    logic [CW-1:0] outRow;
    logic [CW-1:0] outCol;
    logic [0:0]    outCh;
    logic          busy;
    logic          done;
    schedStateT    dbgState;
`ifdef BNN_CONV_SCHED_PERF_EN
    logic [15:0]   perfStall;
    logic [15:0]   perfCyc;
`endif

    bnn_conv_sched_if pix();

    bnn_conv_sched #(.MAX_H(MAX_H), .N_CH(N_CH), .CW(CW)) dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iFRAME_START (frameStart),
        .iMODE        (modeIn),
        .iH           (hIn),
        .pix          (pix),
        .oCONV_START  (convStart),
        .oCONV_EN     (convEn),
        .oSEL         (sel),
        .oW_ADDR      (wAddr),
        .oOUT_VALID   (outValid),
        .oOUT_ROW     (outRow),
        .oOUT_COL     (outCol),
        .oOUT_CH      (outCh),
        .oBUSY        (busy),
        .oDONE        (done),
`ifdef BNN_CONV_SCHED_PERF_EN
        .oPERF_STALL  (perfStall),
        .oPERF_CYC    (perfCyc),
`endif
        .oDBG_STATE   (dbgState)
    );

    // ---------------- scoreboard state ----------------
    int            checks;
    int            fails;
    logic [TW-1:0] exp_q[$];
    bit            monOn;
    int            mW;
    int            mH;
    int            totalBeats;
    int            nReq;
    int            nDone;
    int            nRes;
    int            gapCnt;
    int            cyc;
    int            lastBeatCyc;
    logic          pendValid;
    logic          hs;
    int            k;
    logic [TW-1:0] expTag;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every full 3x3 window of every channel, in stream order.
    task automatic buildModel(input logic m, input int hRaw, output int w, output int h);
        w = m ? 14 : 16;
        h = (hRaw < 3) ? 3 : ((hRaw > MAX_H) ? MAX_H : hRaw);
        exp_q.delete();
        for (int c = 0; c < N_CH; c++)
            for (int r = 2; r < h; r++)
                for (int x = 2; x < w; x++)
                    exp_q.push_back({1'(c), CW'(r - 2), CW'(x - 2)});
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        cyc++;
        if (monOn) begin
            hs = pix.pixValid && pix.pixReady;
            chk("out_valid", 32'(outValid), 32'(pendValid));
            if (outValid) begin
                nRes++;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL extra_result: actual tag=%0h expected none", {outCh, outRow, outCol});
                end else begin
                    expTag = exp_q.pop_front();
                    chk("out_tag", 32'({outCh, outRow, outCol}), 32'(expTag));
                end
            end
            chk("conv_en", 32'(convEn), 32'(hs));
            chk("start_eq_req", 32'(convStart), 32'(pix.frameReq));
            if (pix.pixReady) chk("w_addr_stream", 32'(wAddr), totalBeats / (mH * mW));
            if (pix.frameReq) begin
                nReq++;
                chk("req_at_map_start", totalBeats % (mH * mW), 0);
                chk("w_addr_clear", 32'(wAddr), totalBeats / (mH * mW));
            end
            if (pix.pixReady && !pix.pixValid) gapCnt++;
            k = totalBeats % (mH * mW);
            pendValid = hs && ((k / mW) >= 2) && ((k % mW) >= 2);
            if (hs) begin
                totalBeats++;
                lastBeatCyc = cyc;
            end
            if (done) begin
                nDone++;
                chk("done_latency", cyc - lastBeatCyc, 2);
                chk("busy_at_done", 32'(busy), 0);
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        chk({tag, "_state"},      32'(dbgState), 32'(IDLE));
        chk({tag, "_busy"},       32'(busy), 0);
        chk({tag, "_done"},       32'(done), 0);
        chk({tag, "_out_valid"},  32'(outValid), 0);
        chk({tag, "_out_tag"},    32'({outCh, outRow, outCol}), 0);
        chk({tag, "_conv_start"}, 32'(convStart), 0);
        chk({tag, "_conv_en"},    32'(convEn), 0);
        chk({tag, "_sel"},        32'(sel), 0);
        chk({tag, "_w_addr"},     32'(wAddr), 0);
        chk({tag, "_ready"},      32'(pix.pixReady), 0);
        chk({tag, "_frame_req"},  32'(pix.frameReq), 0);
`ifdef BNN_CONV_SCHED_PERF_EN
        chk({tag, "_perf_stall"}, 32'(perfStall), 0);
        chk({tag, "_perf_cyc"},   32'(perfCyc), 0);
`endif
    endtask

    // ---------------- driver ----------------
    // Runs one layer; enter and leave just after a rising edge.
    task automatic runLayer(input logic m, input int hRaw, input int pct,
                            input bit poke, input int rstAt);
        int w, h, budget, expCount;
        bit poked;
        buildModel(m, hRaw, w, h);
        expCount    = exp_q.size();
        mW          = w;
        mH          = h;
        totalBeats  = 0;
        nReq        = 0;
        nDone       = 0;
        nRes        = 0;
        gapCnt      = 0;
        lastBeatCyc = 0;
        pendValid   = 1'b0;
        poked       = 1'b0;
        monOn       = 1'b1;
        frameStart  = 1'b1;
        modeIn      = m;
        hIn         = CW'(hRaw);
        @(posedge clk); #1;
        frameStart  = 1'b0;
        budget      = 0;
        while (nDone == 0 && budget < 20000) begin
            pix.pixValid = ($urandom_range(0, 99) < pct);
            frameStart   = 1'b0;
            if (poke && !poked && totalBeats >= 30) begin
                frameStart = 1'b1;
                modeIn     = ~m;
                hIn        = CW'(7);
                poked      = 1'b1;
            end
            if (rstAt >= 0 && totalBeats >= rstAt) begin
                rst = 1'b1;
                @(posedge clk); #1;
                monOn        = 1'b0;
                rst          = 1'b0;
                pix.pixValid = 1'b0;
                checkIdleOutputs("mid_rst");
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("post_rst_frame_req", 32'(pix.frameReq), 0);
                    chk("post_rst_busy", 32'(busy), 0);
                    chk("post_rst_done", 32'(done), 0);
                end
                return;
            end
            @(posedge clk); #1;
            budget++;
        end
        if (nDone == 0) begin
            checks++;
            fails++;
            $display("FAIL timeout: actual no done after %0d cycles, required done", budget);
        end
        pix.pixValid = 1'b0;
        frameStart   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        monOn = 1'b0;
        chk("done_count", nDone, 1);
        chk("req_count", nReq, N_CH);
        chk("beat_count", totalBeats, N_CH * h * w);
        chk("result_count", nRes, expCount);
        chk("queue_empty", exp_q.size(), 0);
        chk("sel_latched", 32'(sel), 32'(m));
        chk("busy_after", 32'(busy), 0);
`ifdef BNN_CONV_SCHED_PERF_EN
        chk("perf_stall", 32'(perfStall), gapCnt);
        chk("perf_cyc", 32'(perfCyc), 2 * N_CH + N_CH * h * w + gapCnt);
`endif
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w, h;
        checks       = 0;
        fails        = 0;
        cyc          = 0;
        monOn        = 1'b0;
        rst          = 1'b1;
        frameStart   = 1'b0;
        modeIn       = 1'b0;
        hIn          = '0;
        pix.pixValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdleOutputs("reset");

        // Pin the model to hand-computed values.
        buildModel(1'b1, 4, w, h);
        chk("model_m1h4_count", exp_q.size(), 48);
        chk("model_m1h4_first", 32'(exp_q[0]), 0);
        chk("model_m1h4_ch0_last", 32'(exp_q[23]), 32'({1'b0, 5'd1, 5'd11}));
        chk("model_m1h4_ch1_first", 32'(exp_q[24]), 32'({1'b1, 5'd0, 5'd0}));
        buildModel(1'b0, 1, w, h);
        chk("model_clamp_low_h", h, 3);
        chk("model_clamp_low_count", exp_q.size(), 28);
        buildModel(1'b1, MAX_H + 5, w, h);
        chk("model_clamp_high_h", h, 16);
        chk("model_clamp_high_count", exp_q.size(), 336);

        // Mode 1, 4 lines, no gaps.
        runLayer(1'b1, 4, 100, 1'b0, -1);
        chk("t1_results", nRes, 48);
        chk("t1_beats", totalBeats, 112);

        // Mode 0, 3 lines: 14 results per channel.
        runLayer(1'b0, 3, 100, 1'b0, -1);
        chk("t2_results", nRes, 28);
        chk("t2_frame_reqs", nReq, 2);

        // Random 50% source gaps.
        runLayer(1'b1, 4, 50, 1'b0, -1);
        chk("t3_results", nRes, 48);

        // Start pulse with new mode/height during STREAM is ignored.
        runLayer(1'b0, 5, 70, 1'b1, -1);
        chk("t4_results", nRes, 84);

        // Reset mid-frame, then a clean rerun.
        runLayer(1'b1, 4, 80, 1'b0, 20);
        runLayer(1'b1, 4, 100, 1'b0, -1);
        chk("t5_rerun_results", nRes, 48);

        // Height clamping.
        runLayer(1'b0, 1, 100, 1'b0, -1);
        chk("t6_low_results", nRes, 28);
        runLayer(1'b1, MAX_H + 5, 60, 1'b0, -1);
        chk("t6_high_results", nRes, 336);

        // Random layers.
        for (int i = 0; i < 4; i++) begin
            runLayer(1'($urandom_range(0, 1)), int'($urandom_range(0, 20)),
                     int'($urandom_range(30, 100)), 1'b0, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
